countdown_hms: RTL and testbench
================================

COUNTDOWN_HMS -- requirements
Module: countdown_hms

Interface
REQ-001 Parameter: MAX_H, default 23, highest loadable hour value.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle enable at 1 Hz; each high cycle counts one second.
REQ-005 load  input  1  one-cycle strobe that captures load_h/load_m/load_s.
REQ-006 load_h  input  5  hour preset, range 0..MAX_H.
REQ-007 load_m  input  6  minute preset, range 0..59.
REQ-008 load_s  input  6  second preset, range 0..59.
REQ-009 start  input  1  one-cycle strobe that begins or resumes the countdown.
REQ-010 pause  input  1  one-cycle strobe that halts the countdown.
REQ-011 clear  input  1  one-cycle strobe that zeroes the time and returns to IDLE.
REQ-012 hour  output  5  remaining hours, registered.
REQ-013 minute  output  6  remaining minutes, registered.
REQ-014 second  output  6  remaining seconds, registered.
REQ-015 running  output  1  high while the FSM is in RUN.
REQ-016 done  output  1  one-cycle pulse on the cycle the count reaches 00:00:00.
REQ-017 alarm  output  1  level, high in EXPIRED.
REQ-018 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-019 The FSM SHALL have four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-020 Strobe priority SHALL be clear > load > start > pause > tick; only the highest-priority active strobe acts in a cycle.
REQ-021 clear, from any state, SHALL set the time to 00:00:00 and the FSM to IDLE, and SHALL drop alarm on the next edge.
REQ-022 load SHALL be accepted in IDLE, PAUSE or EXPIRED, and SHALL be ignored in RUN.
REQ-023 An accepted in-range load SHALL update hour/minute/second on the next edge and SHALL move the FSM to IDLE, clearing alarm.
REQ-024 An out-of-range load (load_h>MAX_H, load_m>59 or load_s>59) SHALL leave the time and state unchanged and SHALL pulse load_err for one cycle.
REQ-025 start in IDLE or PAUSE with a nonzero time SHALL move the FSM to RUN; start with time 00:00:00 SHALL be ignored; start in RUN or EXPIRED is a no-op.
REQ-026 pause in RUN SHALL move the FSM to PAUSE; elsewhere it is a no-op.
REQ-027 A tick in RUN SHALL decrement the time by one second, with outputs updated on the edge that samples the tick (latency 1 cycle).
REQ-028 Decrement rule: if second>0, second-1; else second=59 with a borrow to minute.
REQ-029 On a minute borrow: if minute>0, minute-1; else minute=59 with a borrow to hour, which decrements by one.
REQ-030 A tick that takes the time from 00:00:01 to 00:00:00 SHALL move the FSM to EXPIRED and SHALL pulse done in the same update cycle.
REQ-031 tick outside RUN SHALL be ignored, as SHALL a tick in a cycle where a higher-priority strobe acts.
REQ-032 Time SHALL never wrap below 00:00:00; EXPIRED holds 00:00:00.
REQ-033 running SHALL equal (state==RUN) and alarm SHALL equal (state==EXPIRED), both registered.

Reset
REQ-034 While rst_n is low, the block SHALL force state=IDLE, hour=minute=second=0, and done=alarm=load_err=running=0, independent of clk.
REQ-035 Reset deasserted mid-countdown SHALL resume from IDLE at 00:00:00; no prior count is retained.

Structure
REQ-036 Shared package countdown_pkg SHALL hold the FSM state encoding, SEC_MAX=59, MIN_MAX=59, and the field widths 5/6/6.
REQ-037 One sub-module SHALL be used: cnt_down_mod (parameter MOD, inputs dec/ld/ld_val/clr, outputs val and borrow), instantiated for seconds, minutes and hours.
REQ-038 Borrow chaining SHALL be combinational within one cycle; there is no ripple delay between fields.

Verification
REQ-039 Load 00:01:00, start, 1 tick -> 00:00:59, running=1.
REQ-040 Load 01:00:00, start, 1 tick -> 00:59:59; 3599 further ticks -> 00:00:00, done pulses exactly once, alarm=1, running=0.
REQ-041 Load 00:00:05, start, 2 ticks, pause, 3 ticks, start, 1 tick -> 00:00:02.
REQ-042 load_m=60 in IDLE -> load_err pulses one cycle and the time is unchanged; load in RUN -> ignored, no load_err.
REQ-043 clear and tick in the same cycle while RUN at 00:10:00 -> 00:00:00, state IDLE; start at 00:00:00 -> running stays 0.
REQ-044 rst_n asserted low asynchronously mid-RUN between clk edges -> all outputs 0 immediately; after release, tick has no effect until load+start.

Source files
------------

// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the hh:mm:ss countdown timer: FSM state encoding,
// field limits and field widths, plus a small helper used by the top level
// to spot the last second of a countdown.
// ---------------------------------------------------------------------------
package countdown_pkg;

    localparam int H_W     = 5;
    localparam int M_W     = 6;
    localparam int S_W     = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // True when the displayed time is exactly 00:00:01, i.e. the next
    // decrement lands on zero.
    function automatic logic is_last_second(input logic [H_W-1:0] h,
                                            input logic [M_W-1:0] m,
                                            input logic [S_W-1:0] s);
        return (h == '0) && (m == '0) && (s == S_W'(1));
    endfunction

endpackage

// File: rtl/cnt_down_mod.sv
// ---------------------------------------------------------------------------
// cnt_down_mod
// One registered down-counting field (seconds, minutes or hours).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the field to zero (highest priority)
//   ld, ld_val : load a preset value
//   dec        : count down by one; wraps 0 -> MOD-1
//   val        : current field value (registered)
//   borrow     : combinational, high when dec hits a zero field, so the next
//                more significant field decrements in the same cycle
// ---------------------------------------------------------------------------
module cnt_down_mod #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dec,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] val,
    output logic         borrow
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (ld) begin
            val_d = ld_val;
        end else if (dec) begin
            val_d = (val_q == '0) ? W'(MOD - 1) : (val_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val    = val_q;
    assign borrow = dec && (val_q == '0);

endmodule

// File: rtl/countdown_hms.sv
// ---------------------------------------------------------------------------
// countdown_hms
// Loadable hh:mm:ss countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   tick                       : 1 Hz enable, one second per high cycle
//   load, load_h/m/s           : preset strobe and value (rejected if out of range)
//   start, pause, clear        : control strobes; priority clear>load>start>pause>tick
//   hour, minute, second       : remaining time (registered)
//   running, alarm             : state==RUN / state==EXPIRED (registered)
//   done                       : one-cycle pulse when the count reaches zero
//   load_err                   : one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
module countdown_hms
    import countdown_pkg::*;
#(
    parameter int MAX_H = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           load,
    input  logic [H_W-1:0] load_h,
    input  logic [M_W-1:0] load_m,
    input  logic [S_W-1:0] load_s,
    input  logic           start,
    input  logic           pause,
    input  logic           clear,
    output logic [H_W-1:0] hour,
    output logic [M_W-1:0] minute,
    output logic [S_W-1:0] second,
    output logic           running,
    output logic           done,
    output logic           alarm,
    output logic           load_err
);

    localparam logic [H_W-1:0] MAX_H_V = H_W'(MAX_H);
    localparam logic [M_W-1:0] MIN_MAX_V = M_W'(MIN_MAX);
    localparam logic [S_W-1:0] SEC_MAX_V = S_W'(SEC_MAX);

    state_t state_q, state_d;
    logic   running_q, alarm_q, done_q, load_err_q;
    logic   done_d, load_err_d;
    logic   fld_clr, fld_ld, sec_dec;
    logic   sec_borrow, min_borrow, hour_borrow;
    logic   time_zero, load_ok;

    assign time_zero = (hour == '0) && (minute == '0) && (second == '0);
    assign load_ok   = (load_h <= MAX_H_V) && (load_m <= MIN_MAX_V) && (load_s <= SEC_MAX_V);

    // Only the highest-priority active strobe acts; lower ones are dropped
    // for this cycle even if the winner turns out to be a no-op.
    always_comb begin
        state_d    = state_q;
        fld_clr    = 1'b0;
        fld_ld     = 1'b0;
        sec_dec    = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            fld_clr = 1'b1;
            state_d = ST_IDLE;
        end else if (load) begin
            if (state_q != ST_RUN) begin
                if (load_ok) begin
                    fld_ld  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (start) begin
            if (((state_q == ST_IDLE) || (state_q == ST_PAUSE)) && !time_zero) begin
                state_d = ST_RUN;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (tick && (state_q == ST_RUN)) begin
            sec_dec = 1'b1;
            if (is_last_second(hour, minute, second)) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == ST_RUN);
            alarm_q    <= (state_d == ST_EXPIRED);
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Borrows chain combinationally: seconds -> minutes -> hours in one cycle.
    cnt_down_mod #(.MOD(SEC_MAX + 1), .W(S_W)) u_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec    (sec_dec),
        .ld     (fld_ld),
        .clr    (fld_clr),
        .ld_val (load_s),
        .val    (second),
        .borrow (sec_borrow)
    );

    cnt_down_mod #(.MOD(MIN_MAX + 1), .W(M_W)) u_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec    (sec_borrow),
        .ld     (fld_ld),
        .clr    (fld_clr),
        .ld_val (load_m),
        .val    (minute),
        .borrow (min_borrow)
    );

    // Hours never underflow: a borrow out of a zero hour would need the
    // whole time to be zero, and RUN is left before that can happen.
    cnt_down_mod #(.MOD(MAX_H + 1), .W(H_W)) u_hour (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec    (min_borrow),
        .ld     (fld_ld),
        .clr    (fld_clr),
        .ld_val (load_h),
        .val    (hour),
        .borrow (hour_borrow)
    );

    assign running  = running_q;
    assign alarm    = alarm_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_hms.sv
// ---------------------------------------------------------------------------
// tb_countdown_hms
// Directed bench for countdown_hms. Each step pushes its expected outputs
// {hour, minute, second, running, done, alarm, load_err} to a scoreboard
// queue, drives one cycle of stimulus, then pops and compares.
// ---------------------------------------------------------------------------
module tb_countdown_hms;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [4:0] load_h = '0;
    logic [5:0] load_m = '0, load_s = '0;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic       running, done, alarm, load_err;

    typedef struct {
        string       tag;
        logic [20:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    countdown_hms #(.MAX_H(23)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (load),
        .load_h   (load_h),
        .load_m   (load_m),
        .load_s   (load_s),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .running  (running),
        .done     (done),
        .alarm    (alarm),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pack(input int h, m, s, input logic r, d, a, e);
        return {5'(h), 6'(m), 6'(s), r, d, a, e};
    endfunction

    task automatic push(input string tag, input int h, m, s, input logic r, d, a, e);
        exp_t x;
        x.tag = tag;
        x.val = pack(h, m, s, r, d, a, e);
        sb.push_back(x);
    endtask

    task automatic check_pop();
        exp_t        x;
        logic [20:0] o;
        o = {hour, minute, second, running, done, alarm, load_err};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%h required=entry", o);
        end else begin
            x = sb.pop_front();
            assert (o === x.val) else begin
                errors++;
                $error("FAIL %s: observed %0d:%0d:%0d r%0b d%0b a%0b e%0b, required %0d:%0d:%0d r%0b d%0b a%0b e%0b",
                       x.tag, o[20:16], o[15:10], o[9:4], o[3], o[2], o[1], o[0],
                       x.val[20:16], x.val[15:10], x.val[9:4], x.val[3], x.val[2], x.val[1], x.val[0]);
            end
            $display("check %s -> %0d:%0d:%0d run=%0b done=%0b alarm=%0b err=%0b",
                     x.tag, hour, minute, second, running, done, alarm, load_err);
        end
    endtask

    // One clock of stimulus; strobes are dropped 1 time unit after the edge.
    task automatic cyc(input logic t, ld, st, pa, cl, input int h = 0, m = 0, s = 0);
        tick = t; load = ld; start = st; pause = pa; clear = cl;
        load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
        @(posedge clk);
        #1;
        tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    endtask

    initial begin
        int done_cnt;
        // Reset asserted asynchronously before any clock edge
        #1 rst_n = 1'b0;
        #1;
        push("reset_async", 0, 0, 0, 0, 0, 0, 0); check_pop();
        @(posedge clk); #1;
        push("reset_held", 0, 0, 0, 0, 0, 0, 0); check_pop();
        #2 rst_n = 1'b1;

        // Load 00:01:00, start, one tick
        push("load_0100", 0, 1, 0, 0, 0, 0, 0);   cyc(0, 1, 0, 0, 0, 0, 1, 0); check_pop();
        push("start_0100", 0, 1, 0, 1, 0, 0, 0);  cyc(0, 0, 1, 0, 0);          check_pop();
        push("tick_0059", 0, 0, 59, 1, 0, 0, 0);  cyc(1, 0, 0, 0, 0);          check_pop();
        push("load_in_run", 0, 0, 59, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0, 5, 5, 5); check_pop();
        push("clear_run", 0, 0, 0, 0, 0, 0, 0);   cyc(0, 0, 0, 0, 1);          check_pop();

        // Range checks on load
        push("load_0007", 0, 0, 7, 0, 0, 0, 0);   cyc(0, 1, 0, 0, 0, 0, 0, 7);  check_pop();
        push("load_m60", 0, 0, 7, 0, 0, 0, 1);    cyc(0, 1, 0, 0, 0, 0, 60, 0); check_pop();
        push("err_gone", 0, 0, 7, 0, 0, 0, 0);    cyc(0, 0, 0, 0, 0);           check_pop();
        push("load_h24", 0, 0, 7, 0, 0, 0, 1);    cyc(0, 1, 0, 0, 0, 24, 0, 0); check_pop();

        // Pause / resume
        push("load_0005", 0, 0, 5, 0, 0, 0, 0);   cyc(0, 1, 0, 0, 0, 0, 0, 5);  check_pop();
        push("start_5", 0, 0, 5, 1, 0, 0, 0);     cyc(0, 0, 1, 0, 0);           check_pop();
        push("tick_4", 0, 0, 4, 1, 0, 0, 0);      cyc(1, 0, 0, 0, 0);           check_pop();
        push("tick_3", 0, 0, 3, 1, 0, 0, 0);      cyc(1, 0, 0, 0, 0);           check_pop();
        push("pause_tick", 0, 0, 3, 0, 0, 0, 0);  cyc(1, 0, 0, 1, 0);           check_pop();
        for (int i = 0; i < 3; i++) begin
            push("tick_paused", 0, 0, 3, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); check_pop();
        end
        push("resume", 0, 0, 3, 1, 0, 0, 0);      cyc(0, 0, 1, 0, 0);           check_pop();
        push("tick_2", 0, 0, 2, 1, 0, 0, 0);      cyc(1, 0, 0, 0, 0);           check_pop();

        // clear beats tick; start at zero ignored
        push("pause_2", 0, 0, 2, 0, 0, 0, 0);     cyc(0, 0, 0, 1, 0);           check_pop();
        push("load_1000", 0, 10, 0, 0, 0, 0, 0);  cyc(0, 1, 0, 0, 0, 0, 10, 0); check_pop();
        push("start_1000", 0, 10, 0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);           check_pop();
        push("clear_tick", 0, 0, 0, 0, 0, 0, 0);  cyc(1, 0, 0, 0, 1);           check_pop();
        push("start_zero", 0, 0, 0, 0, 0, 0, 0);  cyc(0, 0, 1, 0, 0);           check_pop();

        // Full hour with borrows through every field
        push("load_1h", 1, 0, 0, 0, 0, 0, 0);     cyc(0, 1, 0, 0, 0, 1, 0, 0);  check_pop();
        push("start_1h", 1, 0, 0, 1, 0, 0, 0);    cyc(0, 0, 1, 0, 0);           check_pop();
        push("tick_5959", 0, 59, 59, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);           check_pop();
        done_cnt = 0;
        for (int i = 0; i < 3598; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (done) done_cnt++;
        end
        checks++;
        assert (done_cnt == 0) else begin
            errors++;
            $error("FAIL early_done: observed %0d pulses, required 0", done_cnt);
        end
        push("at_0001", 0, 0, 1, 1, 0, 0, 0);     cyc(0, 0, 0, 0, 0);           check_pop();
        push("expire", 0, 0, 0, 0, 1, 1, 0);      cyc(1, 0, 0, 0, 0);           check_pop();
        push("done_once", 0, 0, 0, 0, 0, 1, 0);   cyc(1, 0, 0, 0, 0);           check_pop();
        push("start_exp", 0, 0, 0, 0, 0, 1, 0);   cyc(0, 0, 1, 0, 0);           check_pop();
        push("load_exp", 0, 0, 3, 0, 0, 0, 0);    cyc(0, 1, 0, 0, 0, 0, 0, 3);  check_pop();

        // Asynchronous reset mid-run
        push("start_3", 0, 0, 3, 1, 0, 0, 0);     cyc(0, 0, 1, 0, 0);           check_pop();
        push("tick_2b", 0, 0, 2, 1, 0, 0, 0);     cyc(1, 0, 0, 0, 0);           check_pop();
        #2 rst_n = 1'b0;
        #1;
        push("rst_midrun", 0, 0, 0, 0, 0, 0, 0);  check_pop();
        cyc(1, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        push("tick_after_rst", 0, 0, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);        check_pop();
        push("start_after_rst", 0, 0, 0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0);       check_pop();
        push("load_0002", 0, 0, 2, 0, 0, 0, 0);   cyc(0, 1, 0, 0, 0, 0, 0, 2);  check_pop();
        push("start_0002", 0, 0, 2, 1, 0, 0, 0);  cyc(0, 0, 1, 0, 0);           check_pop();
        push("tick_0001", 0, 0, 1, 1, 0, 0, 0);   cyc(1, 0, 0, 0, 0);           check_pop();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover: observed %0d entries, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
